// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b type definitions: memory-port arbiter state encoding and grant modes.
package lc3b_types;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width that stays at least one bit so single-requester builds still have a grant field.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational winner selection: highest-index fixed priority, or round-robin from a start index.
module rr_picker
    import lc3b_types::*;
#(
    parameter int N   = 2,
    parameter int IDW = idWidth(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] start_i,
    input  logic           mode_i,
    output logic [IDW-1:0] winner_o,
    output logic           valid_o
);

    int             idx;
    logic [IDW-1:0] pos;
    logic           found;

    always_comb begin
        winner_o = '0;
        valid_o  = |req_i;
        idx      = 0;
        pos      = '0;
        found    = 1'b0;
        if (mode_i) begin
            // Walk N slots from the start index, wrapping once, and keep the first requester seen.
            for (int k = 0; k < N; k++) begin
                idx = int'(start_i) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                pos = IDW'(idx);
                if (!found && req_i[pos]) begin
                    winner_o = pos;
                    found    = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_i[i]) begin
                    winner_o = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges N request ports onto one physical memory port; a grant is held until the memory responds.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int  N_PORTS = 2,
    parameter int  ADDR_W  = 16,
    parameter int  DATA_W  = 16,
    parameter int  RR_MODE = ARB_FIXED,
    localparam int IDW     = idWidth(N_PORTS),
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PORTS*ADDR_W-1:0] req_addr,
    input  logic [N_PORTS*BE_W-1:0]   req_byte_enable,
    input  logic [N_PORTS-1:0]        req_read,
    input  logic [N_PORTS-1:0]        req_write,
    input  logic [N_PORTS*DATA_W-1:0] req_wdata,
    output logic [N_PORTS-1:0]        req_resp,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [ADDR_W-1:0]         pmem_address,
    output logic [BE_W-1:0]           pmem_byte_enable,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [DATA_W-1:0]         pmem_wdata,
    input  logic                      pmem_resp,
    input  logic [DATA_W-1:0]         pmem_rdata,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_PORTS - 1);
    localparam logic           MODE     = (RR_MODE == ARB_RR);

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] grantId_q, grantId_d;
    logic [IDW-1:0] lastGrant_q, lastGrant_d;
    logic [IDW-1:0] startIdx;
    logic [IDW-1:0] pickIdx;
    logic           pickValid;
    logic [IDW-1:0] sel;

    assign startIdx = (lastGrant_q == LAST_IDX) ? '0 : lastGrant_q + 1'b1;

    rr_picker #(
        .N   (N_PORTS),
        .IDW (IDW)
    ) uPicker (
        .req_i    (req_read | req_write),
        .start_i  (startIdx),
        .mode_i   (MODE),
        .winner_o (pickIdx),
        .valid_o  (pickValid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grantId_q   <= '0;
            lastGrant_q <= LAST_IDX;
        end else begin
            state_q     <= state_d;
            grantId_q   <= grantId_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grantId_d   = grantId_q;
        lastGrant_d = lastGrant_q;
        if (state_q == ARB_IDLE) begin
            if (pickValid) begin
                state_d     = ARB_BUSY;
                grantId_d   = pickIdx;
                lastGrant_d = pickIdx;
            end
        end else if (pmem_resp) begin
            state_d = ARB_IDLE;
        end
    end

    // Port 0 drives the data/address lanes while idle; only the strobes are qualified by busy.
    assign busy             = (state_q == ARB_BUSY);
    assign sel              = busy ? grantId_q : '0;
    assign pmem_address     = req_addr[int'(sel)*ADDR_W +: ADDR_W];
    assign pmem_byte_enable = req_byte_enable[int'(sel)*BE_W +: BE_W];
    assign pmem_wdata       = req_wdata[int'(sel)*DATA_W +: DATA_W];
    assign pmem_read        = busy & req_read[sel];
    assign pmem_write       = busy & req_write[sel];
    assign req_rdata        = pmem_rdata;
    assign grant_id         = grantId_q;

    always_comb begin
        req_resp = '0;
        if (busy && pmem_resp) begin
            req_resp[grantId_q] = 1'b1;
        end
    end

endmodule
